seg7_frame_decoder: RTL and testbench

SEG7_FRAME_DECODER -- requirements
Module: seg7_frame_decoder

---
 rtl/seg7_rx_pkg.sv | 18 +
 rtl/seg7_glyph_lookup.sv | 23 ++
 rtl/seg7_frame_decoder.sv | 159 +++++++++++++++
 tb/tb_seg7_frame_decoder.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/seg7_rx_pkg.sv
// Shared definitions for the serial seven-segment frame receiver: frame size,
// receiver states and the hex glyph table (segment a = bit 0 ... g = bit 6).
package seg7_rx_pkg;

    localparam int FRAME_BITS = 8;

    typedef enum logic {
        ST_IDLE,
        ST_SHIFT
    } rxState_e;

    // Entry i is the segment pattern that displays hex digit i.
    localparam logic [6:0] GLYPH_TABLE [16] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
        7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
    };

endpackage

// File: rtl/seg7_glyph_lookup.sv
// Combinational reverse lookup of a seven-segment pattern to its hex digit;
// match_o is low when the pattern is not one of the sixteen hex glyphs.
module seg7_glyph_lookup
    import seg7_rx_pkg::*;
(
    input  logic [6:0] segments_i,
    output logic [3:0] digit_o,
    output logic       match_o
);

    // Glyphs are unique, so at most one table entry can hit.
    always_comb begin
        digit_o = 4'd0;
        match_o = 1'b0;
        for (int i = 0; i < 16; i++) begin
            if (segments_i == GLYPH_TABLE[i]) begin
                digit_o = 4'(i);
                match_o = 1'b1;
            end
        end
    end

endmodule

// File: rtl/seg7_frame_decoder.sv
// Serial seven-segment frame receiver: shifts in 8-bit {dp,g..a} frames and
// decodes them to a held hex digit. Define SEG7_SEQ_CHECK_EN to enable the
// "digit must count up by one" sequence error flag on io_out[6].
module seg7_frame_decoder
    import seg7_rx_pkg::*;
(
    input  logic [7:0] io_in,
    output logic [7:0] io_out
);

    logic clk, rst, sdata, sframe, clr;
    logic unused_in;

    assign clk       = io_in[0];
    assign rst       = io_in[1];
    assign sdata     = io_in[2];
    assign sframe    = io_in[3];
    assign clr       = io_in[4];
    assign unused_in = ^io_in[7:5];

    rxState_e   state_q, state_d;
    logic [2:0] cnt_q, cnt_d;
    logic [7:0] shift_q, shift_d;
    logic       done_q, done_d;
    logic       abort;
    logic [3:0] digit_q, digit_d;
    logic       dp_q, dp_d;
    logic       valid_q, valid_d;
    logic       ferr_q, ferr_d;
    logic       serr;

    logic [3:0] lookDigit;
    logic       lookMatch;

    // A completed frame sits whole in shift_q during the cycle after its last bit.
    seg7_glyph_lookup u_lookup (
        .segments_i (shift_q[6:0]),
        .digit_o    (lookDigit),
        .match_o    (lookMatch)
    );

`ifdef SEG7_SEQ_CHECK_EN
    logic first_q, first_d;
    logic serr_q, serr_d;
    assign serr = serr_q;
`else
    assign serr = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        shift_d = shift_q;
        done_d  = 1'b0;
        abort   = 1'b0;
        digit_d = digit_q;
        dp_d    = dp_q;
        valid_d = 1'b0;
        ferr_d  = ferr_q;
`ifdef SEG7_SEQ_CHECK_EN
        first_d = first_q;
        serr_d  = serr_q;
`endif

        if (clr) begin
            state_d = ST_IDLE;
            cnt_d   = 3'd0;
            digit_d = 4'd0;
            dp_d    = 1'b0;
            ferr_d  = 1'b0;
`ifdef SEG7_SEQ_CHECK_EN
            first_d = 1'b0;
            serr_d  = 1'b0;
`endif
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (sframe) begin
                        shift_d = {shift_q[6:0], sdata};
                        cnt_d   = 3'd1;
                        state_d = ST_SHIFT;
                    end
                end
                ST_SHIFT: begin
                    if (sframe) begin
                        shift_d = {shift_q[6:0], sdata};
                        cnt_d   = 3'(cnt_q + 3'd1);
                        // Returning to IDLE lets a back-to-back frame start next cycle.
                        if (cnt_q == 3'(FRAME_BITS - 1)) begin
                            done_d  = 1'b1;
                            state_d = ST_IDLE;
                        end
                    end else begin
                        abort   = 1'b1;
                        cnt_d   = 3'd0;
                        state_d = ST_IDLE;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                    cnt_d   = 3'd0;
                end
            endcase

            if (abort) begin
                ferr_d = 1'b1;
            end

            if (done_q) begin
                if (lookMatch) begin
                    digit_d = lookDigit;
                    dp_d    = shift_q[7];
                    valid_d = 1'b1;
                    ferr_d  = 1'b0;
`ifdef SEG7_SEQ_CHECK_EN
                    // digit_q still holds the previous good digit here.
                    serr_d  = first_q && (lookDigit != 4'(digit_q + 4'd1));
                    first_d = 1'b1;
`endif
                end else begin
                    ferr_d = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= 3'd0;
            shift_q <= 8'd0;
            done_q  <= 1'b0;
            digit_q <= 4'd0;
            dp_q    <= 1'b0;
            valid_q <= 1'b0;
            ferr_q  <= 1'b0;
`ifdef SEG7_SEQ_CHECK_EN
            first_q <= 1'b0;
            serr_q  <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            shift_q <= shift_d;
            done_q  <= done_d;
            digit_q <= digit_d;
            dp_q    <= dp_d;
            valid_q <= valid_d;
            ferr_q  <= ferr_d;
`ifdef SEG7_SEQ_CHECK_EN
            first_q <= first_d;
            serr_q  <= serr_d;
`endif
        end
    end

    assign io_out = {dp_q, serr, ferr_q, valid_q, digit_q};

endmodule

// File: tb/tb_seg7_frame_decoder.sv
// Directed scoreboard bench for seg7_frame_decoder: frames are driven serially,
// expected io_out values are queued with the cycle they must appear in.
module tb_seg7_frame_decoder;

`ifdef SEG7_SEQ_CHECK_EN
    localparam bit SEQ_EN = 1'b1;
`else
    localparam bit SEQ_EN = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       sdata = 1'b0;
    logic       sframe = 1'b0;
    logic       clr = 1'b0;
    logic [2:0] spare = 3'b101;
    logic [7:0] io_out;

    int compared = 0;
    int mismatched = 0;
    int cycleCount = 0;

    int         dueQ[$];
    logic [7:0] expQ[$];
    string      tagQ[$];

    logic [3:0] mDigit = 4'd0;
    logic       mDp = 1'b0;
    logic       mFerr = 1'b0;
    logic       mSerr = 1'b0;
    logic       mFirst = 1'b0;

    seg7_frame_decoder dut (
        .io_in  ({spare, clr, sframe, sdata, rst, clk}),
        .io_out (io_out)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cycleCount <= cycleCount + 1;

    task automatic checkOutput(input string tag, input logic [7:0] observed, input logic [7:0] expected);
        compared++;
        assert (observed === expected) else begin
            mismatched++;
            $error("[TB] FAIL %s: observed 0x%02h expected 0x%02h (cycle %0d)", tag, observed, expected, cycleCount);
        end
    endtask

    function automatic logic [4:0] glyphOf(input logic [6:0] s);
        case (s)
            7'h3F: return 5'h10; 7'h06: return 5'h11; 7'h5B: return 5'h12; 7'h4F: return 5'h13;
            7'h66: return 5'h14; 7'h6D: return 5'h15; 7'h7D: return 5'h16; 7'h07: return 5'h17;
            7'h7F: return 5'h18; 7'h6F: return 5'h19; 7'h77: return 5'h1A; 7'h7C: return 5'h1B;
            7'h39: return 5'h1C; 7'h5E: return 5'h1D; 7'h79: return 5'h1E; 7'h71: return 5'h1F;
            default: return 5'h00;
        endcase
    endfunction

    function automatic logic [7:0] modelOut();
        return {mDp, mSerr, mFerr, 1'b0, mDigit};
    endfunction

    task automatic pushExpect(input int due, input logic [7:0] value, input string tag);
        dueQ.push_back(due);
        expQ.push_back(value);
        tagQ.push_back(tag);
    endtask

    task automatic modelClear();
        mDigit = 4'd0; mDp = 1'b0; mFerr = 1'b0; mSerr = 1'b0; mFirst = 1'b0;
    endtask

    // Called while the last bit is on the wire: decode shows two edges later.
    task automatic modelFrame(input logic [7:0] f, input string tag);
        logic [4:0] g;
        logic [3:0] nextD;
        int due;
        g = glyphOf(f[6:0]);
        nextD = mDigit + 4'd1;
        due = cycleCount + 2;
        if (g[4]) begin
            mSerr  = SEQ_EN && mFirst && (g[3:0] != nextD);
            mDigit = g[3:0];
            mDp    = f[7];
            mFerr  = 1'b0;
            mFirst = 1'b1;
            pushExpect(due, modelOut() | 8'h10, tag);
            pushExpect(due + 1, modelOut(), {tag, "_hold"});
        end else begin
            mFerr = 1'b1;
            pushExpect(due, modelOut(), tag);
        end
    endtask

    // Drives nBits of f MSB first; a short frame then drops sframe.
    task automatic applyStimulus(input logic [7:0] f, input int nBits, input string tag);
        for (int i = 0; i < nBits; i++) begin
            @(negedge clk);
            sframe = 1'b1;
            sdata  = f[7 - i];
            if (nBits == 8 && i == 7) modelFrame(f, tag);
        end
        if (nBits < 8) begin
            @(negedge clk);
            sframe = 1'b0;
            sdata  = 1'b0;
            mFerr  = 1'b1;
            pushExpect(cycleCount + 1, modelOut(), tag);
        end
    endtask

    task automatic idleCycles(input int n);
        repeat (n) begin
            @(negedge clk);
            sframe = 1'b0;
            sdata  = 1'b0;
            clr    = 1'b0;
        end
    endtask

    // Every cycle: compare any due expectations and insist valid pulses only when expected.
    always @(negedge clk) begin
        logic expValid;
        expValid = 1'b0;
        while (dueQ.size() > 0 && dueQ[0] <= cycleCount) begin
            checkOutput(tagQ[0], io_out, expQ[0]);
            expValid = expValid | expQ[0][4];
            void'(dueQ.pop_front());
            void'(expQ.pop_front());
            void'(tagQ.pop_front());
        end
        checkOutput("validPulse", {7'd0, io_out[4]}, {7'd0, expValid});
    end

    initial begin
        rst = 1'b1;
        @(negedge clk);
        checkOutput("resetState", io_out, 8'h00);
        @(negedge clk);
        rst = 1'b0;

        $display("[TB] frame 0x3F with dp");
        applyStimulus(8'hBF, 8, "dpFrame");
        idleCycles(3);

        $display("[TB] back-to-back frames");
        applyStimulus(8'h06, 8, "b2bFirst");
        applyStimulus(8'h5B, 8, "b2bSecond");
        idleCycles(3);

        $display("[TB] sequence break 3 -> 5");
        applyStimulus(8'h4F, 8, "seqThree");
        idleCycles(2);
        applyStimulus(8'h6D, 8, "seqFive");
        idleCycles(3);

        $display("[TB] bad glyph then recovery");
        applyStimulus(8'h00, 8, "badGlyph");
        idleCycles(3);
        applyStimulus(8'h3F, 8, "afterBad");
        idleCycles(3);

        $display("[TB] truncated frame then recovery");
        applyStimulus(8'h06, 5, "truncated");
        idleCycles(3);
        applyStimulus(8'h66, 8, "afterTrunc");
        idleCycles(3);

        $display("[TB] clear, then first frame after clear");
        @(negedge clk);
        clr = 1'b1;
        modelClear();
        pushExpect(cycleCount + 1, 8'h00, "clrPulse");
        idleCycles(2);
        applyStimulus(8'hFF, 8, "afterClr");
        idleCycles(3);

        $display("[TB] clear on the last bit of a frame");
        applyStimulus(8'h5B, 7, "unused");
        modelFrame(8'h00, "unusedDrop");
        void'(dueQ.pop_back()); void'(expQ.pop_back()); void'(tagQ.pop_back());
        modelClear();
        idleCycles(3);
        // The 7-bit call above was a truncation; now a proper clr race:
        for (int i = 0; i < 7; i++) begin
            @(negedge clk);
            sframe = 1'b1;
            sdata  = 1'(8'h07 >> (7 - i));
        end
        @(negedge clk);
        sdata = 1'b1;
        clr   = 1'b1;
        modelClear();
        pushExpect(cycleCount + 1, 8'h00, "clrBeatsFrame");
        pushExpect(cycleCount + 2, 8'h00, "clrBeatsFrameAfter");
        idleCycles(3);
        applyStimulus(8'h7D, 8, "afterClrRace");
        idleCycles(3);

        $display("[TB] reset during a frame");
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            sframe = 1'b1;
            sdata  = 1'(8'h4F >> (7 - i));
        end
        @(negedge clk);
        rst    = 1'b1;
        sframe = 1'b0;
        sdata  = 1'b0;
        #1;
        checkOutput("resetMidFrame", io_out, 8'h00);
        modelClear();
        @(negedge clk);
        rst = 1'b0;
        applyStimulus(8'h06, 8, "afterReset");
        idleCycles(4);

        checkOutput("drain", 8'(dueQ.size()), 8'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
